powlib_busarb: RTL and testbench

- Round-robin bus arbiter that shares one bus write interface between B_WRS bus requesters, with burst hold.
- Each requester presents data/address/valid/last. The winner keeps the grant until end of burst or MAXB beats, then the priority pointer rotates.
- Output is registered, one entry, with valid/ready plus nearly-full gating.
- Intended as a fair replacement for the fixed-priority selection in front of crossbar lane output FIFOs. rdnf connects to the downstream bus FIFO wrnf.

---
 rtl/powlib_busarb.sv | 158 +++++++++++++++
 tb/tb_powlib_busarb.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/powlib_busarb.sv
// Round-robin write-bus arbiter with burst hold and a one-entry registered output.
// A winner keeps the bus until its last beat, MAXB beats, or it drops valid.
module powlib_busarb #(
    parameter int B_WRS = 4,
    parameter int B_AW  = 2,
    parameter int B_DW  = 4,
    parameter int MAXB  = 4,
    parameter     ID    = "BUSARB",
    parameter int EDBG  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [B_WRS*B_DW-1:0]      wrdatas,
    input  logic [B_WRS*B_AW-1:0]      wraddrs,
    input  logic [B_WRS-1:0]           wrvlds,
    input  logic [B_WRS-1:0]           wrlasts,
    output logic [B_WRS-1:0]           wrrdys,
    output logic [B_DW-1:0]            rddata,
    output logic [B_AW-1:0]            rdaddr,
    output logic [$clog2(B_WRS)-1:0]   rdsrc,
    output logic                       rdvld,
    input  logic                       rdrdy,
    input  logic                       rdnf
);

    localparam int SW = $clog2(B_WRS);
    localparam int CW = $clog2(MAXB + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] GRANT = 1'b1;

    logic [0:0]    state;
    logic [SW-1:0] ptr;
    logic [SW-1:0] grant;
    logic [CW-1:0] cnt;

    logic [SW-1:0] winner;
    logic          found;

    logic          g_vld;
    logic          g_last;
    logic [B_DW-1:0] g_data;
    logic [B_AW-1:0] g_addr;

    logic          out_free;
    logic          take;
    logic          accept;
    logic [CW-1:0] cnt_inc;
    logic          hit_max;
    logic          release_now;
    logic [SW-1:0] ptr_next;

    // Rotating scan: first valid requester at or after ptr wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < B_WRS; k++) begin
            if (!found && wrvlds[(int'(ptr) + k) % B_WRS]) begin
                found  = 1'b1;
                winner = SW'((int'(ptr) + k) % B_WRS);
            end
        end
    end

    assign g_vld  = wrvlds[grant];
    assign g_last = wrlasts[grant];
    assign g_data = wrdatas[int'(grant)*B_DW +: B_DW];
    assign g_addr = wraddrs[int'(grant)*B_AW +: B_AW];

    // The output slot can take a beat if empty or being drained this cycle.
    assign out_free = !rdvld || rdrdy;
    assign take     = (state == GRANT) && !rdnf && out_free;
    assign accept   = take && g_vld;

    always_comb begin
        wrrdys        = '0;
        wrrdys[grant] = take;
    end

    assign cnt_inc  = cnt + 1'b1;
    assign hit_max  = (cnt_inc == CW'(MAXB));
    assign ptr_next = (grant == SW'(B_WRS - 1)) ? '0 : grant + 1'b1;

    // A stall keeps the grant; only a dropped valid counts as abandonment.
    assign release_now = (state == GRANT) &&
                         (!g_vld || (accept && (g_last || hit_max)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            ptr   <= '0;
            grant <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state <= GRANT;
                        grant <= winner;
                        cnt   <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        state <= IDLE;
                        ptr   <= ptr_next;
                        cnt   <= '0;
                    end else if (accept) begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdvld <= 1'b0;
        end else if (accept) begin
            rdvld <= 1'b1;
        end else if (rdrdy) begin
            rdvld <= 1'b0;
        end
    end

    // Payload is qualified by rdvld, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            rddata <= g_data;
            rdaddr <= g_addr;
            rdsrc  <= grant;
        end
    end

    // Debug trace of the most recent grant/release, visible hierarchically.
    if (EDBG != 0) begin : g_dbg
        logic [SW-1:0] dbg_grant;
        logic [CW-1:0] dbg_cnt;
        logic          dbg_rel;
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dbg_grant <= '0;
                dbg_cnt   <= '0;
                dbg_rel   <= 1'b0;
            end else if (state == IDLE && found) begin
                dbg_grant <= winner;
                dbg_cnt   <= '0;
                dbg_rel   <= 1'b0;
            end else if (release_now) begin
                dbg_grant <= grant;
                dbg_cnt   <= accept ? cnt_inc : cnt;
                dbg_rel   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_powlib_busarb.sv
// Directed bench for powlib_busarb: per-requester source model plus
// hand-computed grant orders and output sequences.
module tb_powlib_busarb;

    localparam int N  = 4;
    localparam int AW = 2;
    localparam int DW = 4;
    localparam int MB = 4;

    logic              clk;
    logic              rst;
    logic [N*DW-1:0]   wrdatas;
    logic [N*AW-1:0]   wraddrs;
    logic [N-1:0]      wrvlds;
    logic [N-1:0]      wrlasts;
    logic [N-1:0]      wrrdys;
    logic [DW-1:0]     rddata;
    logic [AW-1:0]     rdaddr;
    logic [1:0]        rdsrc;
    logic              rdvld;
    logic              rdrdy;
    logic              rdnf;

    int checks = 0;
    int fails  = 0;

    // Source model: rem = beats left (-1 = endless), data advances on accept.
    int          rem      [N];
    bit          lst_end  [N];
    bit          lst_all  [N];
    logic [DW-1:0] dat    [N];
    logic [DW-1:0] exp_next [N];
    logic [N-1:0]  acc;

    powlib_busarb #(.B_WRS(N), .B_AW(AW), .B_DW(DW), .MAXB(MB), .ID("BUSARB"), .EDBG(0)) dut (
        .clk(clk), .rst(rst),
        .wrdatas(wrdatas), .wraddrs(wraddrs), .wrvlds(wrvlds), .wrlasts(wrlasts),
        .wrrdys(wrrdys),
        .rddata(rddata), .rdaddr(rdaddr), .rdsrc(rdsrc), .rdvld(rdvld),
        .rdrdy(rdrdy), .rdnf(rdnf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic src_drive();
        for (int i = 0; i < N; i++) begin
            wrvlds[i]            = (rem[i] != 0);
            wrlasts[i]           = lst_all[i] || (lst_end[i] && rem[i] == 1);
            wrdatas[i*DW +: DW]  = dat[i];
            wraddrs[i*AW +: AW]  = 2'(i);
        end
    endtask

    task automatic src_advance(input logic [N-1:0] a);
        for (int i = 0; i < N; i++) begin
            if (a[i]) begin
                dat[i] = dat[i] + 1'b1;
                if (rem[i] > 0) rem[i] = rem[i] - 1;
            end
        end
    endtask

    task automatic src_clear();
        for (int i = 0; i < N; i++) begin
            rem[i] = 0; lst_end[i] = 0; lst_all[i] = 0; dat[i] = '0; exp_next[i] = '0;
        end
        acc = '0;
    endtask

    // One cycle: at the negedge, retire last cycle's accepts, drive, then sample.
    task automatic step(input logic rr, input logic nf);
        @(negedge clk);
        src_advance(acc);
        src_drive();
        rdrdy = rr;
        rdnf  = nf;
        #1;
        acc = wrrdys & wrvlds;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        src_clear();
        src_drive();
        rdrdy = 1'b1;
        rdnf  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        src_clear();
        for (int i = 0; i < N; i++) rem[i] = -1;
        src_drive();
        rdrdy = 1'b1;
        rdnf  = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (rdvld !== 1'b0) begin fails++; $display("FAIL reset_rdvld: got %0b expected 0", rdvld); end
        checks++;
        if (wrrdys !== 4'b0000) begin fails++; $display("FAIL reset_wrrdys: got %b expected 0000", wrrdys); end
        do_reset();
    endtask

    task automatic test_single_burst();
        logic [N-1:0]  rdy_e [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        logic          vld_e [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [DW-1:0] dat_e [5] = '{4'd0, 4'd5, 4'd6, 4'd7, 4'd0};
        do_reset();
        rem[2] = 3; lst_end[2] = 1; dat[2] = 4'd5;
        src_drive();
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'b0);
            checks++;
            if (wrrdys !== rdy_e[c]) begin fails++; $display("FAIL single_wrrdys c%0d: got %b expected %b", c+1, wrrdys, rdy_e[c]); end
            checks++;
            if (rdvld !== vld_e[c]) begin fails++; $display("FAIL single_rdvld c%0d: got %0b expected %0b", c+1, rdvld, vld_e[c]); end
            if (vld_e[c]) begin
                checks++;
                if (rddata !== dat_e[c] || rdsrc !== 2'd2 || rdaddr !== 2'd2) begin
                    fails++;
                    $display("FAIL single_beat c%0d: got d=%0h src=%0d a=%0d expected d=%0h src=2 a=2", c+1, rddata, rdsrc, rdaddr, dat_e[c]);
                end
            end
        end
        // ptr should now be 3: with 0 and 3 both requesting, 3 wins.
        rem[0] = 1; lst_end[0] = 1; rem[3] = 1; lst_end[3] = 1;
        src_drive();
        step(1'b1, 1'b0);
        checks++;
        if (wrrdys !== 4'b1000) begin fails++; $display("FAIL single_ptr_next: got %b expected 1000", wrrdys); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] oh;
        do_reset();
        for (int i = 0; i < N; i++) begin
            rem[i] = -1; lst_all[i] = 1; dat[i] = 4'(8 + i); exp_next[i] = 4'(8 + i);
        end
        src_drive();
        for (int c = 1; c <= 10; c++) begin
            step(1'b1, 1'b0);
            if (c % 2 == 1) begin
                oh = 4'(1 << (((c - 1) / 2) % 4));
                checks++;
                if (wrrdys !== oh || rdvld !== 1'b0) begin
                    fails++;
                    $display("FAIL rr_grant c%0d: got rdy=%b vld=%0b expected rdy=%b vld=0", c, wrrdys, rdvld, oh);
                end
            end else begin
                checks++;
                if (rdvld !== 1'b1 || rdsrc !== 2'(((c - 2) / 2) % 4)) begin
                    fails++;
                    $display("FAIL rr_src c%0d: got vld=%0b src=%0d expected vld=1 src=%0d", c, rdvld, rdsrc, ((c - 2) / 2) % 4);
                end
                checks++;
                if (rddata !== exp_next[rdsrc]) begin
                    fails++;
                    $display("FAIL rr_data c%0d: got %0h expected %0h", c, rddata, exp_next[rdsrc]);
                end
                exp_next[rdsrc] = exp_next[rdsrc] + 1'b1;
            end
        end
    endtask

    task automatic test_maxb_release();
        int exp_src [13] = '{0,0,0,0,1,0,0,0,0,1,0,0,1};
        int b = 0;
        do_reset();
        rem[0] = 10;
        rem[1] = -1; lst_all[1] = 1;
        src_drive();
        for (int c = 0; c < 80 && b < 13; c++) begin
            step(1'b1, 1'b0);
            if (rdvld === 1'b1) begin
                checks++;
                if (int'(rdsrc) !== exp_src[b]) begin
                    fails++;
                    $display("FAIL maxb_src beat%0d: got %0d expected %0d", b, rdsrc, exp_src[b]);
                end
                checks++;
                if (rddata !== exp_next[rdsrc]) begin
                    fails++;
                    $display("FAIL maxb_data beat%0d: got %0h expected %0h", b, rddata, exp_next[rdsrc]);
                end
                exp_next[rdsrc] = exp_next[rdsrc] + 1'b1;
                b++;
            end
        end
        checks++;
        if (b != 13) begin fails++; $display("FAIL maxb_timeout: got %0d beats expected 13", b); end
    endtask

    task automatic test_nearly_full();
        int exp_src [5] = '{1,1,1,1,3};
        int b = 0;
        int nf_cnt = 0;
        logic nf;
        do_reset();
        rem[1] = 6;
        rem[3] = -1; lst_all[3] = 1;
        src_drive();
        for (int c = 0; c < 60 && b < 5; c++) begin
            nf = (nf_cnt < 3) && ((6 - rem[1] + (acc[1] ? 1 : 0)) == 2);
            step(1'b1, nf);
            if (nf) begin
                nf_cnt++;
                checks++;
                if (wrrdys !== 4'b0000) begin fails++; $display("FAIL nf_wrrdys: got %b expected 0000", wrrdys); end
            end
            if (rdvld === 1'b1) begin
                checks++;
                if (int'(rdsrc) !== exp_src[b] || rddata !== exp_next[rdsrc]) begin
                    fails++;
                    $display("FAIL nf_beat%0d: got src=%0d d=%0h expected src=%0d d=%0h", b, rdsrc, rddata, exp_src[b], exp_next[rdsrc]);
                end
                exp_next[rdsrc] = exp_next[rdsrc] + 1'b1;
                b++;
            end
        end
        checks++;
        if (b != 5 || nf_cnt != 3) begin fails++; $display("FAIL nf_timeout: got beats=%0d nf=%0d expected beats=5 nf=3", b, nf_cnt); end
    endtask

    task automatic test_back_to_back();
        logic          rr_e  [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [N-1:0]  rdy_e [7] = '{4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        logic          vld_e [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [DW-1:0] dat_e [7] = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd3, 4'd0};
        do_reset();
        rem[2] = 3; lst_end[2] = 1; dat[2] = 4'd1;
        src_drive();
        for (int c = 0; c < 7; c++) begin
            step(rr_e[c], 1'b0);
            checks++;
            if (wrrdys !== rdy_e[c]) begin fails++; $display("FAIL stall_wrrdys c%0d: got %b expected %b", c+1, wrrdys, rdy_e[c]); end
            checks++;
            if (rdvld !== vld_e[c]) begin fails++; $display("FAIL stall_rdvld c%0d: got %0b expected %0b", c+1, rdvld, vld_e[c]); end
            if (vld_e[c]) begin
                checks++;
                if (rddata !== dat_e[c]) begin fails++; $display("FAIL stall_data c%0d: got %0h expected %0h", c+1, rddata, dat_e[c]); end
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        rem[1] = 1; lst_end[1] = 1; dat[1] = 4'd1;
        rem[3] = -1; dat[3] = 4'd3;
        src_drive();
        step(1'b1, 1'b0);
        checks++;
        if (wrrdys !== 4'b0010) begin fails++; $display("FAIL rstm_g1: got %b expected 0010", wrrdys); end
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        checks++;
        if (wrrdys !== 4'b1000) begin fails++; $display("FAIL rstm_g3: got %b expected 1000", wrrdys); end
        step(1'b1, 1'b0);
        checks++;
        if (rdvld !== 1'b1 || rdsrc !== 2'd3 || rddata !== 4'd3) begin
            fails++;
            $display("FAIL rstm_beat: got vld=%0b src=%0d d=%0h expected vld=1 src=3 d=3", rdvld, rdsrc, rddata);
        end
        rem[1] = -1; lst_end[1] = 0;
        src_drive();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (rdvld !== 1'b0) begin fails++; $display("FAIL rstm_async_vld: got %0b expected 0", rdvld); end
        checks++;
        if (wrrdys !== 4'b0000) begin fails++; $display("FAIL rstm_async_rdy: got %b expected 0000", wrrdys); end
        @(negedge clk);
        rst = 1'b1;
        acc = '0;
        #1;
        checks++;
        if (rdvld !== 1'b0) begin fails++; $display("FAIL rstm_post_vld: got %0b expected 0", rdvld); end
        @(negedge clk);
        #1;
        checks++;
        if (wrrdys !== 4'b0010) begin fails++; $display("FAIL rstm_regrant: got %b expected 0010", wrrdys); end
    endtask

    initial begin
        rst     = 1'b1;
        wrdatas = '0;
        wraddrs = '0;
        wrvlds  = '0;
        wrlasts = '0;
        rdrdy   = 1'b1;
        rdnf    = 1'b0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_maxb_release();
        test_nearly_full();
        test_back_to_back();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
